// File: rtl/bmd_mc_defs.sv
// Shared memory-controller types for the ANB burst splitters.
// Sub-burst descriptors are shared by the read-side and write-side splitters.
package bmd_mc_defs;

    typedef logic [31:0] smc_addr_t;
    typedef logic [31:0] smc_data_t;
    typedef logic [15:0] task_data_len_t;

    typedef struct packed {
        task_data_len_t len;
        logic           final_sub;
    } sub_burst_desc_t;

    typedef struct packed {
        smc_addr_t      addr;
        task_data_len_t len;
    } anb_addr_beat_t;

    typedef struct packed {
        smc_data_t data;
        logic      last;
    } anb_data_beat_t;

    typedef enum logic {
        IDLE,
        SPLIT
    } split_state_t;

    function automatic task_data_len_t min_len(input task_data_len_t a,
                                               input task_data_len_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/anb_wr_burst_splitter_if.sv
// ANB address and data channel bundles; m drives the payload, s returns ready.
interface anb_addr_channel_if;
    import bmd_mc_defs::*;

    logic           avalid;
    logic           aready;
    smc_addr_t      addr;
    task_data_len_t len;

    modport m (output avalid, output addr, output len, input aready);
    modport s (input avalid, input addr, input len, output aready);
endinterface

interface anb_data_channel_if;
    import bmd_mc_defs::*;

    logic      valid;
    logic      ready;
    smc_data_t data;
    logic      last;

    modport m (output valid, output data, output last, input ready);
    modport s (input valid, input data, input last, output ready);
endinterface

// File: rtl/anb_len_fifo_m.sv
// Synchronous descriptor FIFO; head is always visible on rdata when not empty.
// A pop on an empty FIFO is ignored, so a same-cycle push never bypasses.
module anb_len_fifo_m #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     rdata,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    T             mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/reg_stage_m.sv
// Single-entry valid/ready register slice with full throughput.
// Only the valid bit is reset; the payload register is free-running.
module reg_stage_m #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic vld_p1;
    T     data_p1;

    assign in_ready  = !rst && (!vld_p1 || out_ready);
    assign out_valid = vld_p1 && !rst;
    assign out_data  = data_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            data_p1 <= in_data;
        end
    end

endmodule

// File: rtl/anb_wr_burst_splitter.sv
// Splits ANB write bursts into sub-bursts limited by MAX_BURST and BOUNDARY,
// and regenerates data-side last from a queue of sub-burst descriptors.
module anb_wr_burst_splitter
    import bmd_mc_defs::*;
#(
    parameter int MAX_BURST      = 16,
    parameter int BOUNDARY       = 64,
    parameter int LEN_FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    anb_addr_channel_if.s      m_a,
    anb_addr_channel_if.m      s_a,
    anb_data_channel_if.s      m_d,
    anb_data_channel_if.m      s_d,
    output logic               err
);

    localparam task_data_len_t MAX_LEN  = task_data_len_t'(MAX_BURST);
    localparam task_data_len_t BND_LEN  = task_data_len_t'(BOUNDARY);
    localparam smc_addr_t      BND_MASK = smc_addr_t'(BOUNDARY - 1);

    split_state_t    state;
    split_state_t    state_nxt;
    smc_addr_t       cur_addr;
    smc_addr_t       cur_addr_nxt;
    task_data_len_t  remain;
    task_data_len_t  remain_nxt;
    task_data_len_t  room;
    task_data_len_t  sub_len;
    logic            final_sub;
    logic            a_ready;
    logic            issue;
    logic            a_stage_ready;
    logic            a_out_valid;
    anb_addr_beat_t  a_beat;
    anb_addr_beat_t  a_out;

    sub_burst_desc_t desc_in;
    sub_burst_desc_t head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;

    task_data_len_t  beat_cnt;
    logic            regen_last;
    logic            d_ready;
    logic            d_xfer;
    logic            d_stage_ready;
    logic            d_out_valid;
    anb_data_beat_t  d_beat;
    anb_data_beat_t  d_out;

    // Address side: carve the request into boundary-safe sub-bursts.
    assign room      = BND_LEN - task_data_len_t'(cur_addr & BND_MASK);
    assign sub_len   = min_len(remain, min_len(MAX_LEN, room));
    assign final_sub = (remain == sub_len);
    assign a_beat    = '{addr: cur_addr, len: sub_len};
    assign desc_in   = '{len: sub_len, final_sub: final_sub};

    always_comb begin
        state_nxt    = state;
        cur_addr_nxt = cur_addr;
        remain_nxt   = remain;
        a_ready      = 1'b0;
        issue        = 1'b0;
        case (state)
            IDLE: begin
                a_ready = !rst;
                if (m_a.avalid && !rst) begin
                    cur_addr_nxt = m_a.addr;
                    remain_nxt   = m_a.len;
                    state_nxt    = (m_a.len != '0) ? SPLIT : IDLE;
                end
            end
            SPLIT: begin
                // Address stage and descriptor FIFO must both take the sub-burst.
                if (a_stage_ready && !fifo_full) begin
                    issue        = 1'b1;
                    cur_addr_nxt = cur_addr + smc_addr_t'(sub_len);
                    remain_nxt   = remain - sub_len;
                    if (final_sub) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cur_addr <= '0;
            remain   <= '0;
        end else begin
            state    <= state_nxt;
            cur_addr <= cur_addr_nxt;
            remain   <= remain_nxt;
        end
    end

    assign m_a.aready = a_ready;

    reg_stage_m #(.T(anb_addr_beat_t)) u_a_stage (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue),
        .in_ready  (a_stage_ready),
        .in_data   (a_beat),
        .out_valid (a_out_valid),
        .out_ready (s_a.aready),
        .out_data  (a_out)
    );

    assign s_a.avalid = a_out_valid;
    assign s_a.addr   = a_out.addr;
    assign s_a.len    = a_out.len;

    anb_len_fifo_m #(.T(sub_burst_desc_t), .DEPTH(LEN_FIFO_DEPTH)) u_len_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (issue),
        .wdata (desc_in),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Data side: frame beats against the descriptor at the FIFO head.
    assign regen_last = (beat_cnt == head.len - task_data_len_t'(1));
    assign d_ready    = !rst && !fifo_empty && d_stage_ready;
    assign d_xfer     = m_d.valid && d_ready;
    assign fifo_pop   = d_xfer && regen_last;
    assign d_beat     = '{data: m_d.data, last: regen_last};
    assign m_d.ready  = d_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            err      <= 1'b0;
        end else if (d_xfer) begin
            beat_cnt <= regen_last ? '0 : beat_cnt + task_data_len_t'(1);
            // Upstream last is only a consistency check, never used for framing.
            if (m_d.last != (regen_last && head.final_sub)) begin
                err <= 1'b1;
            end
        end
    end

    reg_stage_m #(.T(anb_data_beat_t)) u_d_stage (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (d_xfer),
        .in_ready  (d_stage_ready),
        .in_data   (d_beat),
        .out_valid (d_out_valid),
        .out_ready (s_d.ready),
        .out_data  (d_out)
    );

    assign s_d.valid = d_out_valid;
    assign s_d.data  = d_out.data;
    assign s_d.last  = d_out.last;

endmodule

// File: tb/tb_anb_wr_burst_splitter.sv
// Scoreboard bench for anb_wr_burst_splitter: directed requests with
// hand-computed sub-bursts, monitor compares s_a and s_d against queues.
`timescale 1ns/1ps
module tb_anb_wr_burst_splitter;
    import bmd_mc_defs::*;

    logic clk = 1'b0;
    logic rst;
    logic err;

    always #5 clk = ~clk;

    anb_addr_channel_if m_a ();
    anb_addr_channel_if s_a ();
    anb_data_channel_if m_d ();
    anb_data_channel_if s_d ();

    anb_wr_burst_splitter #(
        .MAX_BURST      (16),
        .BOUNDARY       (64),
        .LEN_FIFO_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .m_a (m_a),
        .s_a (s_a),
        .m_d (m_d),
        .s_d (s_d),
        .err (err)
    );

    typedef struct { smc_addr_t addr; task_data_len_t len; } sa_t;
    typedef struct { smc_data_t data; logic last; } sd_t;

    sa_t            exp_a [$];
    sd_t            exp_d [$];
    task_data_len_t exp_sub [$];
    sa_t            ea;
    sd_t            ed;
    int             total = 0;
    int             bad = 0;
    int             sa_hs = 0;
    int             hs0;
    bit             mon_en = 1'b0;
    bit             sd_rand = 1'b0;
    task_data_len_t sub_rem = '0;
    smc_data_t      dval = 32'h1000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes an output transfer.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (s_a.avalid && s_a.aready) begin
                sa_hs++;
                if (exp_a.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sa_extra: got addr=%0h len=%0d, want no sub-burst", s_a.addr, s_a.len);
                end else begin
                    ea = exp_a.pop_front();
                    check("sa_addr", s_a.addr, ea.addr);
                    check("sa_len", 32'(s_a.len), 32'(ea.len));
                end
            end
            if (s_d.valid && s_d.ready) begin
                if (exp_d.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sd_extra: got data=%0h, want no beat", s_d.data);
                end else begin
                    ed = exp_d.pop_front();
                    check("sd_data", s_d.data, ed.data);
                    check("sd_last", 32'(s_d.last), 32'(ed.last));
                end
            end
        end
    end

    initial begin
        s_d.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 s_d.ready = sd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want test end");
        $fatal(1, "watchdog");
    end

    task automatic expect_sub(input smc_addr_t a, input task_data_len_t l);
        sa_t e;
        e.addr = a;
        e.len  = l;
        exp_a.push_back(e);
        exp_sub.push_back(l);
    endtask

    task automatic do_req(input smc_addr_t a, input task_data_len_t l);
        bit ok;
        ok = 1'b0;
        m_a.avalid = 1'b1;
        m_a.addr   = a;
        m_a.len    = l;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = m_a.aready;
            @(posedge clk);
        end
        #1 m_a.avalid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL req_timeout: got aready=0, want 1");
        end
    endtask

    // Beats are numbered from 1; m_d.last is raised on beat last_at (0 = never).
    task automatic send_data(input int n, input int last_at);
        bit  ok;
        sd_t e;
        for (int i = 1; i <= n; i++) begin
            if (sub_rem == 0 && exp_sub.size() > 0) begin
                sub_rem = exp_sub.pop_front();
            end
            e.data = dval;
            e.last = (sub_rem == 1);
            if (sub_rem != 0) begin
                sub_rem = sub_rem - 1'b1;
            end
            exp_d.push_back(e);
            m_d.valid = 1'b1;
            m_d.data  = dval;
            m_d.last  = (i == last_at);
            ok = 1'b0;
            for (int k = 0; k < 300 && !ok; k++) begin
                @(negedge clk);
                ok = m_d.ready;
                @(posedge clk);
            end
            #1;
            m_d.valid = 1'b0;
            m_d.last  = 1'b0;
            dval++;
            if (!ok) begin
                total++;
                bad++;
                $display("FAIL md_timeout: got ready=0, want 1");
                return;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 1000 && (exp_a.size() != 0 || exp_d.size() != 0); i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        check({name, "_a_left"}, 32'(exp_a.size()), 32'd0);
        check({name, "_d_left"}, 32'(exp_d.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        m_a.avalid  = 1'b0;
        m_a.addr    = '0;
        m_a.len     = '0;
        m_d.valid   = 1'b0;
        m_d.data    = '0;
        m_d.last    = 1'b0;
        s_a.aready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sa_valid", 32'(s_a.avalid), 32'd0);
        check("rst_sd_valid", 32'(s_d.valid), 32'd0);
        check("rst_ma_ready", 32'(m_a.aready), 32'd0);
        check("rst_md_ready", 32'(m_d.ready), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("idle_ma_ready", 32'(m_a.aready), 32'd1);
        @(posedge clk);
        #1;

        // Single aligned full-size burst, with issue latency check.
        expect_sub(32'd0, 16'd16);
        do_req(32'd0, 16'd16);
        @(negedge clk);
        check("lat_cycle1_valid", 32'(s_a.avalid), 32'd0);
        @(negedge clk);
        check("lat_cycle2_valid", 32'(s_a.avalid), 32'd1);
        @(posedge clk);
        #1 send_data(16, 16);
        wait_drain("t_len16");
        check("t_len16_err", 32'(err), 32'd0);

        // Length split: 40 -> 16, 16, 8.
        expect_sub(32'd0, 16'd16);
        expect_sub(32'd16, 16'd16);
        expect_sub(32'd32, 16'd8);
        do_req(32'd0, 16'd40);
        send_data(40, 40);
        wait_drain("t_len40");
        check("t_len40_err", 32'(err), 32'd0);

        // Boundary split: 60+10 -> (60,4), (64,6).
        expect_sub(32'd60, 16'd4);
        expect_sub(32'd64, 16'd6);
        do_req(32'd60, 16'd10);
        send_data(10, 10);
        wait_drain("t_bnd");
        check("t_bnd_err", 32'(err), 32'd0);

        // Zero-length request is swallowed without touching data.
        do_req(32'd300, 16'd0);
        m_d.valid = 1'b1;
        m_d.data  = dval;
        repeat (5) begin
            @(negedge clk);
            check("len0_md_ready", 32'(m_d.ready), 32'd0);
            check("len0_sa_valid", 32'(s_a.avalid), 32'd0);
        end
        @(posedge clk);
        #1 m_d.valid = 1'b0;
        @(negedge clk);
        check("len0_idle", 32'(m_a.aready), 32'd1);
        @(posedge clk);
        #1;

        // Backpressured s_a, data held back so the descriptor FIFO fills.
        s_a.aready = 1'b0;
        sd_rand    = 1'b1;
        hs0        = sa_hs;
        for (int k = 0; k < 5; k++) begin
            expect_sub(32'd128 + 32'(16 * k), 16'd16);
        end
        do_req(32'd128, 16'd80);
        repeat (20) @(posedge clk);
        #1 s_a.aready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stall_sa_count", 32'(sa_hs - hs0), 32'd4);
        check("stall_ma_ready", 32'(m_a.aready), 32'd0);
        @(posedge clk);
        #1 send_data(80, 80);
        wait_drain("t_stall");
        sd_rand = 1'b0;
        check("t_stall_err", 32'(err), 32'd0);

        // Upstream last on beat 5 of an 8-beat burst.
        expect_sub(32'd256, 16'd8);
        do_req(32'd256, 16'd8);
        send_data(4, 0);
        @(negedge clk);
        check("err_before", 32'(err), 32'd0);
        @(posedge clk);
        #1 send_data(1, 1);
        @(negedge clk);
        check("err_set", 32'(err), 32'd1);
        @(posedge clk);
        #1 send_data(3, 0);
        wait_drain("t_err");
        check("err_sticky", 32'(err), 32'd1);

        // Reset pulsed during beat 3 of a 40-beat burst.
        mon_en = 1'b0;
        do_req(32'd0, 16'd40);
        send_data(2, 0);
        m_d.valid = 1'b1;
        m_d.data  = dval;
        rst       = 1'b1;
        @(negedge clk);
        check("mid_rst_sa_valid", 32'(s_a.avalid), 32'd0);
        check("mid_rst_sd_valid", 32'(s_d.valid), 32'd0);
        check("mid_rst_ma_ready", 32'(m_a.aready), 32'd0);
        check("mid_rst_md_ready", 32'(m_d.ready), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        m_d.valid = 1'b0;
        exp_a.delete();
        exp_d.delete();
        exp_sub.delete();
        sub_rem = '0;
        @(negedge clk);
        check("post_rst_sa_valid", 32'(s_a.avalid), 32'd0);
        check("post_rst_sd_valid", 32'(s_d.valid), 32'd0);
        check("post_rst_ma_ready", 32'(m_a.aready), 32'd1);
        check("post_rst_md_ready", 32'(m_d.ready), 32'd0);
        check("post_rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1 mon_en = 1'b1;
        expect_sub(32'd0, 16'd16);
        do_req(32'd0, 16'd16);
        send_data(16, 16);
        wait_drain("t_after_rst");
        check("t_after_rst_err", 32'(err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
